nibble_serial_add_ctrl: RTL and testbench
=========================================

NIBBLE_SERIAL_ADD_CTRL -- requirements
Module: nibble_serial_add_ctrl

Interface
REQ-001 Parameter WIDTH, default 16: operand/result width in bits; SHALL be a multiple of 4 and at least 8.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 resetn  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  operand pair offered.
REQ-005 in_ready  output  1  controller accepts operands.
REQ-006 a  input  WIDTH  operand A.
REQ-007 b  input  WIDTH  operand B.
REQ-008 sub  input  1  subtract request (present only with ADD_SUB_EN).
REQ-009 out_valid  output  1  result held.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 sum  output  WIDTH  result.
REQ-012 c_out  output  1  carry out of MSB nibble (for subtract, 1 = no borrow).
REQ-013 overflow  output  1  two's-complement overflow of the result.

Function
REQ-014 The controller SHALL sequence one shared 4-bit ripple adder over WIDTH/4 nibbles, LSB nibble first, one nibble per cycle.
REQ-015 FSM states SHALL be IDLE, RUN, DONE.
REQ-016 IDLE: in_ready=1; on in_valid=1, the controller SHALL latch a, b (and sub), clear the nibble index, load carry=0 (or 1 for subtract), and enter RUN.
REQ-017 RUN: in_ready=0; each cycle SHALL add nibble[idx] of A and B with the carry register, write the 4-bit sum into sum[4*idx+3:4*idx], register the nibble carry, and increment idx.
REQ-018 After the nibble with idx=WIDTH/4-1, the FSM SHALL enter DONE; latency from accept to out_valid SHALL be exactly WIDTH/4+1 cycles.
REQ-019 DONE: out_valid=1, sum/c_out/overflow SHALL stay stable until out_valid&&out_ready, then the FSM SHALL return to IDLE.
REQ-020 overflow SHALL equal the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1.
REQ-021 in_valid during RUN or DONE SHALL be ignored (not accepted, no state change).
REQ-022 out_ready asserted outside DONE SHALL have no effect.
REQ-023 Index counter SHALL be ceil(log2(WIDTH/4)) bits wide and SHALL NOT wrap inside RUN.
REQ-024 The DONE-to-IDLE transition SHALL take one cycle; no back-to-back accept in the handshake cycle.

Reset
REQ-025 On resetn=0, at any time including mid-RUN, state SHALL go to IDLE asynchronously; in_ready=1, out_valid=0, sum=0, c_out=0, overflow=0, idx=0, carry=0.
REQ-026 A partial operation interrupted by reset SHALL be discarded; no result is produced.

Configuration
REQ-027 Macro NIBBLE_SERIAL_ADD_SUB_EN defined: sub port exists; sub=1 SHALL compute A-B by inverting B nibbles and carry-in 1.
REQ-028 Macro undefined: sub port absent; only A+B computed; carry-in always 0.

Structure
REQ-029 Shared package nibble_add_pkg SHALL hold the FSM state enum (IDLE, RUN, DONE) and constant NIBBLE_W=4.
REQ-030 One sub-module nibble_adder (4-bit ripple-carry of 1-bit full adders, inputs a, b, c_in; outputs s, c_out, and carry into bit 3) SHALL be instantiated exactly once.

Verification
REQ-031 WIDTH=16, 0x00FF+0x0001 -> sum=0x0100, c_out=0, overflow=0, out_valid 5 cycles after accept.
REQ-032 0xFFFF+0x0001 -> sum=0x0000, c_out=1, overflow=0; 0x7FFF+0x0001 -> sum=0x8000, overflow=1.
REQ-033 Hold out_ready=0 for 10 cycles in DONE with in_valid=1 -> result stable, in_ready=0, no new accept; release -> IDLE next cycle.
REQ-034 Assert resetn=0 two cycles into RUN -> immediate IDLE, out_valid=0, sum=0; next operation 0x1234+0x1111 -> 0x2345.
REQ-035 With NIBBLE_SERIAL_ADD_SUB_EN, sub=1: 0x0005-0x0007 -> sum=0xFFFE, c_out=0, overflow=0; 0x8000-0x0001 -> sum=0x7FFF, overflow=1.

Source files
------------

// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared types and constants for the nibble-serial adder controller.
package nibble_add_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/nibble_serial_add_ctrl_if.sv
// Operand/result handshake bundle for nibble_serial_add_ctrl.
// The sub signal exists only when NIBBLE_SERIAL_ADD_SUB_EN is defined.
interface nibble_serial_add_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef NIBBLE_SERIAL_ADD_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             overflow;

`ifdef NIBBLE_SERIAL_ADD_SUB_EN
    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, c_out, overflow
    );
    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, c_out, overflow
    );
`else
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, sum, c_out, overflow
    );
    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, sum, c_out, overflow
    );
`endif

endinterface

// File: rtl/nibble_serial_add_ctrl_adder.sv
// 4-bit ripple-carry adder built from 1-bit full adders; also exposes the
// carry into bit 3 so the controller can derive signed overflow.
module nibble_adder
    import nibble_add_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                c_in,
    output logic [NIBBLE_W-1:0] s,
    output logic                c_out,
    output logic                c3
);

    logic [NIBBLE_W:0] c;

    assign c[0] = c_in;

    for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign c_out = c[NIBBLE_W];
    assign c3    = c[NIBBLE_W-1];

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial add controller: one shared 4-bit adder walks WIDTH/4 nibbles,
// LSB first. Define NIBBLE_SERIAL_ADD_SUB_EN to add the sub (A-B) request.
module nibble_serial_add_ctrl
    import nibble_add_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    nibble_serial_add_ctrl_if.slave  bus
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = $clog2(NIBBLES);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBBLES - 1);

    state_t               state;
    logic [WIDTH-1:0]     a_r;
    logic [WIDTH-1:0]     b_r;
    logic [IDX_W-1:0]     idx;
    logic                 carry;
    logic [WIDTH-1:0]     sum_r;
    logic                 c_out_r;
    logic                 ovf_r;
    logic                 in_ready_r;
    logic                 out_valid_r;
`ifdef NIBBLE_SERIAL_ADD_SUB_EN
    logic                 sub_r;
`endif

    logic [NIBBLE_W-1:0]  nib_a;
    logic [NIBBLE_W-1:0]  nib_b;
    logic [NIBBLE_W-1:0]  nib_s;
    logic                 nib_co;
    logic                 nib_c3;

    always_comb begin
        nib_a = a_r[int'(idx)*NIBBLE_W +: NIBBLE_W];
        nib_b = b_r[int'(idx)*NIBBLE_W +: NIBBLE_W];
`ifdef NIBBLE_SERIAL_ADD_SUB_EN
        // Subtraction is A + ~B + 1; the +1 comes from the carry preload.
        nib_b = nib_b ^ {NIBBLE_W{sub_r}};
`endif
    end

    nibble_adder u_nibble_adder (
        .a     (nib_a),
        .b     (nib_b),
        .c_in  (carry),
        .s     (nib_s),
        .c_out (nib_co),
        .c3    (nib_c3)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            a_r         <= '0;
            b_r         <= '0;
            idx         <= '0;
            carry       <= 1'b0;
            sum_r       <= '0;
            c_out_r     <= 1'b0;
            ovf_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
`ifdef NIBBLE_SERIAL_ADD_SUB_EN
            sub_r       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_r        <= bus.a;
                        b_r        <= bus.b;
                        idx        <= '0;
`ifdef NIBBLE_SERIAL_ADD_SUB_EN
                        sub_r      <= bus.sub;
                        carry      <= bus.sub;
`else
                        carry      <= 1'b0;
`endif
                        in_ready_r <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    sum_r[int'(idx)*NIBBLE_W +: NIBBLE_W] <= nib_s;
                    carry <= nib_co;
                    // idx holds at LAST instead of wrapping; DONE takes over.
                    if (idx == LAST) begin
                        c_out_r     <= nib_co;
                        ovf_r       <= nib_co ^ nib_c3;
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.sum       = sum_r;
    assign bus.c_out     = c_out_r;
    assign bus.overflow  = ovf_r;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed self-checking bench for nibble_serial_add_ctrl (WIDTH=16).
// Subtract vectors run only when NIBBLE_SERIAL_ADD_SUB_EN is defined.
module tb_nibble_serial_add_ctrl;

    localparam int WIDTH = 16;
    localparam int LAT   = WIDTH / 4 + 1;

    logic clk = 1'b0;
    logic resetn;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    nibble_serial_add_ctrl_if #(.WIDTH(WIDTH)) bus ();

    nibble_serial_add_ctrl #(.WIDTH(WIDTH)) u_dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input logic sb,
                          input logic rdy_early, output int lat);
        int guard = 0;
        while (!bus.in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("in_ready_wait", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.a        = av;
        bus.b        = bv;
`ifdef NIBBLE_SERIAL_ADD_SUB_EN
        bus.sub      = sb;
`else
        if (sb) $display("note: sub ignored in add-only build");
`endif
        bus.out_ready = rdy_early;
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic finish_op(input string tag);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, "_ov_drop"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_rdy_back"}, 32'(bus.in_ready), 32'd1);
    endtask

    task automatic do_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                         input logic sb, input logic [15:0] es, input logic ec, input logic eo);
        int lat;
        run_op(av, bv, sb, 1'b0, lat);
        check({tag, "_lat"}, 32'(lat), 32'(LAT));
        check({tag, "_sum"}, 32'(bus.sum), 32'(es));
        check({tag, "_cout"}, 32'(bus.c_out), 32'(ec));
        check({tag, "_ovf"}, 32'(bus.overflow), 32'(eo));
        finish_op(tag);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

    initial begin
        int lat;
        logic [15:0] held;

        resetn        = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;
`ifdef NIBBLE_SERIAL_ADD_SUB_EN
        bus.sub       = 1'b0;
`endif
        #12;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_sum", 32'(bus.sum), 32'd0);
        check("rst_cout", 32'(bus.c_out), 32'd0);
        check("rst_ovf", 32'(bus.overflow), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        do_op("add_00ff", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
        do_op("add_ffff", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_op("add_7fff", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        do_op("add_abcd", 16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0, 1'b0);
        do_op("add_8000", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

        // Hold result in DONE while a new operand pair is offered.
        run_op(16'h0003, 16'h0004, 1'b0, 1'b0, lat);
        check("hold_lat", 32'(lat), 32'(LAT));
        bus.in_valid = 1'b1;
        bus.a        = 16'h5555;
        bus.b        = 16'h1111;
        held = 16'h0007;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_sum", 32'(bus.sum), 32'(held));
            check("hold_out_valid", 32'(bus.out_valid), 32'd1);
            check("hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        check("hold_rel_ov", 32'(bus.out_valid), 32'd0);
        check("hold_rel_rdy", 32'(bus.in_ready), 32'd1);
        check("hold_rel_sum", 32'(bus.sum), 32'(held));
        @(negedge clk);
        check("hold_no_accept", 32'(bus.in_ready), 32'd1);

        // Reset two cycles into RUN discards the partial operation.
        bus.in_valid = 1'b1;
        bus.a        = 16'hFFFF;
        bus.b        = 16'hFFFF;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_sum", 32'(bus.sum), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 6; i++) @(negedge clk);
        check("midrst_discard", 32'(bus.out_valid), 32'd0);

        // out_ready held high throughout RUN has no effect until DONE.
        run_op(16'h1234, 16'h1111, 1'b0, 1'b1, lat);
        check("post_rst_lat", 32'(lat), 32'(LAT));
        check("post_rst_sum", 32'(bus.sum), 32'h2345);
        check("post_rst_cout", 32'(bus.c_out), 32'd0);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("post_rst_idle", 32'(bus.in_ready), 32'd1);

`ifdef NIBBLE_SERIAL_ADD_SUB_EN
        do_op("sub_5_7", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        do_op("sub_8000", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        do_op("sub_eq", 16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
